// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared types and opcode constants for the ALU arbiter
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam logic [3:0] OP_EQ = 4'b1101;
  localparam logic [3:0] OP_LT = 4'b1110;

  typedef struct packed {
    logic [3:0] cmd;
    logic [7:0] a;
    logic [7:0] b;
    logic       sc;
  } alu_req_t;

  // The ALU only produces a meaningful compare flag for the two compare opcodes.
  function automatic logic one_is_valid(input logic [3:0] cmd);
    return (cmd == OP_EQ) || (cmd == OP_LT);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request/response handshake bundle between requesters and the arbiter
interface alu_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0][3:0]  req_cmd;
  logic [NREQ-1:0][7:0]  req_a;
  logic [NREQ-1:0][7:0]  req_b;
  logic [NREQ-1:0]       req_sc;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic [7:0]            rsp_rslt;
  logic                  rsp_sc;
  logic                  rsp_pari;
  logic                  rsp_one;

  modport master (
    output req_valid, req_cmd, req_a, req_b, req_sc, rsp_ready,
    input  req_ready, rsp_valid, rsp_rslt, rsp_sc, rsp_pari, rsp_one
  );

  modport slave (
    input  req_valid, req_cmd, req_a, req_b, req_sc, rsp_ready,
    output req_ready, rsp_valid, rsp_rslt, rsp_sc, rsp_pari, rsp_one
  );
endinterface

// File: rtl/alu_arbiter_pick.sv
// rtl/alu_arbiter_pick.sv - combinational grant selector, search starts at ptr and wraps
module arb_pick #(
  parameter int NREQ  = 2,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req_valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      int j;
      j = (int'(ptr) + i) % NREQ;
      if (!found && req_valid[j]) begin
        found     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one 8-bit ALU among NREQ requesters; ALU_ARB_RR_EN selects round-robin over fixed priority
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  alu_arbiter_if.slave     bus,
  output logic [3:0]       alu_cmd,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic             alu_sc,
  input  logic [7:0]       alu_rslt,
  input  logic             alu_sc_o,
  input  logic             alu_pari,
  input  logic             alu_one,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_EXEC = EXEC;
  localparam logic [1:0] S_RESP = RESP;

  logic [1:0]       state;
  alu_req_t         launch;
  logic [IDX_W-1:0] owner;
  logic [NREQ-1:0]  rsp_valid_r;
  logic [7:0]       rsp_rslt_r;
  logic             rsp_sc_r;
  logic             rsp_pari_r;
  logic             rsp_one_r;
  logic [NREQ-1:0]  grant;
  logic [IDX_W-1:0] gidx;
  logic [IDX_W-1:0] ptr;

`ifdef ALU_ARB_RR_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (state == S_IDLE && |bus.req_valid) begin
      ptr <= (gidx == IDX_W'(NREQ - 1)) ? '0 : gidx + IDX_W'(1);
    end
  end
`else
  assign ptr = '0;
`endif

  arb_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
    .req_valid (bus.req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (gidx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      launch      <= '0;
      owner       <= '0;
      rsp_valid_r <= '0;
      rsp_rslt_r  <= '0;
      rsp_sc_r    <= 1'b0;
      rsp_pari_r  <= 1'b0;
      rsp_one_r   <= 1'b0;
      ops_done    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|bus.req_valid) begin
            launch <= '{cmd: bus.req_cmd[gidx], a: bus.req_a[gidx],
                        b: bus.req_b[gidx], sc: bus.req_sc[gidx]};
            owner  <= gidx;
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_rslt_r  <= alu_rslt;
          rsp_sc_r    <= alu_sc_o;
          rsp_pari_r  <= alu_pari;
          rsp_one_r   <= one_is_valid(launch.cmd) ? alu_one : 1'b0;
          rsp_valid_r <= NREQ'(1) << owner;
          state       <= S_RESP;
        end
        S_RESP: begin
          // Only the owner's ready can complete; rsp_valid_r is one-hot on the owner.
          if (|(rsp_valid_r & bus.rsp_ready)) begin
            rsp_valid_r <= '0;
            state       <= S_IDLE;
            if (ops_done != '1) ops_done <= ops_done + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state == S_IDLE) ? grant : '0;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rslt  = rsp_rslt_r;
  assign bus.rsp_sc    = rsp_sc_r;
  assign bus.rsp_pari  = rsp_pari_r;
  assign bus.rsp_one   = rsp_one_r;

  // The ALU always sees the launch register, so its inputs only move on an accept.
  assign alu_cmd = launch.cmd;
  assign alu_a   = launch.a;
  assign alu_b   = launch.b;
  assign alu_sc  = launch.sc;
  assign busy    = (state != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with a behavioural ALU
module tb_alu_arbiter;

  localparam int NREQ  = 2;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [3:0]       alu_cmd;
  logic [7:0]       alu_a, alu_b;
  logic             alu_sc;
  logic [7:0]       alu_rslt;
  logic             alu_sc_o, alu_pari, alu_one;
  logic             busy;
  logic [CNT_W-1:0] ops_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         idx;
    logic [7:0] rslt;
    logic       sc;
    logic       pari;
    logic       one;
  } exp_t;

  exp_t exp_q[$];

  alu_arbiter_if #(.NREQ(NREQ)) bus ();

  alu_arbiter #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus.slave),
    .alu_cmd  (alu_cmd),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_sc   (alu_sc),
    .alu_rslt (alu_rslt),
    .alu_sc_o (alu_sc_o),
    .alu_pari (alu_pari),
    .alu_one  (alu_one),
    .busy     (busy),
    .ops_done (ops_done)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: compare flag is garbage (1) for non-compare opcodes.
  always_comb begin
    alu_rslt = '0;
    alu_sc_o = 1'b0;
    alu_one  = 1'b1;
    case (alu_cmd)
      4'b0000: {alu_sc_o, alu_rslt} = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_sc};
      4'b0001: {alu_sc_o, alu_rslt} = {1'b0, alu_a} - {1'b0, alu_b};
      4'b0010: alu_rslt = alu_a | alu_b;
      4'b1101: begin alu_rslt = {7'd0, alu_a == alu_b}; alu_one = (alu_a == alu_b); end
      4'b1110: begin alu_rslt = {7'd0, alu_a < alu_b};  alu_one = (alu_a < alu_b);  end
      default: ;
    endcase
    alu_pari = ^alu_rslt;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input int idx, input logic [7:0] r, input logic sc, input logic p, input logic one);
    exp_t e;
    e.idx = idx; e.rslt = r; e.sc = sc; e.pari = p; e.one = one;
    exp_q.push_back(e);
  endtask

  // Monitor: pop and compare on every response handshake.
  always @(negedge clk) begin
    if (reset_n && |(bus.rsp_valid & bus.rsp_ready)) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_owner", 32'(bus.rsp_valid), 32'(1) << e.idx);
        check("rsp_rslt",  32'(bus.rsp_rslt),  32'(e.rslt));
        check("rsp_sc",    32'(bus.rsp_sc),    32'(e.sc));
        check("rsp_pari",  32'(bus.rsp_pari),  32'(e.pari));
        check("rsp_one",   32'(bus.rsp_one),   32'(e.one));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
    bus.req_cmd[i] = c;
    bus.req_a[i]   = a;
    bus.req_b[i]   = b;
    bus.req_sc[i]  = 1'b0;
  endtask

  // Waits (bounded) at negedges until a grant is offered.
  task automatic wait_grant(input string name);
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (bus.req_ready != '0) return;
      tick();
    end
    check(name, 32'(bus.req_ready), 32'hFFFF_FFFF);
  endtask

  task automatic wait_idle(input string name);
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (!busy) return;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  int exp_grant[5];

  initial begin
`ifdef ALU_ARB_RR_EN
    exp_grant = '{0, 1, 0, 1, 0};
`else
    exp_grant = '{0, 0, 0, 0, 0};
`endif
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    set_req(0, 4'h0, 8'd0, 8'd0);
    set_req(1, 4'h0, 8'd0, 8'd0);
    tick();
    @(negedge clk);
    check("reset_req_ready", 32'(bus.req_ready), 32'd0);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp_rslt",  32'(bus.rsp_rslt),  32'd0);
    check("reset_alu",       {alu_cmd, alu_a, alu_b, alu_sc}, 32'd0);
    check("reset_busy",      32'(busy), 32'd0);
    check("reset_ops_done",  32'(ops_done), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // Single request: 5 + 7.
    bus.rsp_ready = 2'b11;
    set_req(0, 4'b0000, 8'd5, 8'd7);
    bus.req_valid = 2'b01;
    @(negedge clk);
    check("single_req_ready", 32'(bus.req_ready), 32'b01);
    push(0, 8'd12, 1'b0, 1'b0, 1'b0);
    tick();
    bus.req_valid = 2'b00;
    @(negedge clk);
    check("single_exec_busy",  32'(busy), 32'd1);
    check("single_exec_nrsp",  32'(bus.rsp_valid), 32'd0);
    check("single_exec_alu",   {16'd0, alu_a, alu_b}, {16'd0, 8'd5, 8'd7});
    tick();
    @(negedge clk);
    check("single_latency", 32'(bus.rsp_valid), 32'b01);
    tick();
    @(negedge clk);
    check("single_ops_done", 32'(ops_done), 32'd1);
    check("single_idle", 32'(busy), 32'd0);

    // Simultaneous requests, then counter saturation.
    pulse_reset();
    set_req(0, 4'b0001, 8'd9, 8'd4);
    set_req(1, 4'b0010, 8'h30, 8'h0D);
    bus.req_valid = 2'b11;
    for (int k = 0; k < 5; k++) begin
      wait_grant("sim_grant_timeout");
      check("sim_grant", 32'(bus.req_ready), 32'(1) << exp_grant[k]);
      if (exp_grant[k] == 0) push(0, 8'd5, 1'b0, 1'b0, 1'b0);
      else                   push(1, 8'h3D, 1'b0, 1'b1, 1'b0);
      tick();
    end
    bus.req_valid = 2'b00;
    wait_idle("sim_idle_timeout");
    tick();
    @(negedge clk);
    check("sat_ops_done", 32'(ops_done), 32'd3);

    // Backpressure on req1, non-owner ready pulse, req0 waiting.
    tick();
    bus.rsp_ready = 2'b00;
    set_req(1, 4'b1110, 8'd3, 8'd9);
    bus.req_valid = 2'b10;
    @(negedge clk);
    check("bp_grant", 32'(bus.req_ready), 32'b10);
    push(1, 8'd1, 1'b0, 1'b1, 1'b1);
    tick();
    set_req(0, 4'b0000, 8'd200, 8'd100);
    bus.req_valid = 2'b01;
    tick();
    for (int c = 0; c < 5; c++) begin
      bus.rsp_ready = (c == 2) ? 2'b01 : 2'b00;
      @(negedge clk);
      check("bp_rsp_valid", 32'(bus.rsp_valid), 32'b10);
      check("bp_rsp_data",  {23'd0, bus.rsp_one, bus.rsp_rslt}, {23'd0, 1'b1, 8'd1});
      check("bp_req_ready", 32'(bus.req_ready), 32'd0);
      tick();
    end
    bus.rsp_ready = 2'b11;
    @(negedge clk);
    check("bp_no_accept_on_handshake", 32'(bus.req_ready), 32'd0);
    tick();
    wait_grant("bp_grant0_timeout");
    check("bp_grant0", 32'(bus.req_ready), 32'b01);
    push(0, 8'h2C, 1'b1, 1'b1, 1'b0);
    tick();
    bus.req_valid = 2'b00;
    wait_idle("bp_idle_timeout");

    // Reset during EXEC discards the operation.
    tick();
    set_req(0, 4'b0000, 8'd1, 8'd1);
    bus.req_valid = 2'b01;
    wait_grant("rst_grant_timeout");
    tick();
    bus.req_valid = 2'b00;
    @(negedge clk);
    check("rst_in_exec", 32'(busy), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("rst_busy",      32'(busy), 32'd0);
    check("rst_rsp",       {bus.rsp_valid, bus.rsp_rslt, bus.rsp_one}, 32'd0);
    check("rst_alu",       {alu_cmd, alu_a, alu_b, alu_sc}, 32'd0);
    check("rst_ops_done",  32'(ops_done), 32'd0);
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
